// File: rtl/register_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and default sizing for the two-write/two-read
//            register file (register_file_mp) and its clear sequencer.
// Contents : rf_state_t    - clear-sequencer state (RF_CLEAR, RF_RUN)
//            c_DEFAULT_*   - default data width / address width
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int c_DEFAULT_DATA_WIDTH = 64;
  localparam int c_DEFAULT_ADDR_WIDTH = 6;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp_if
// Purpose  : Bus bundle between decode/writeback and register_file_mp.
// Ports    : readAdr1/2    - read addresses            (master -> slave)
//            readData1/2   - combinational read data   (slave  -> master)
//            writeAdr1/2   - write addresses           (master -> slave)
//            writeData1/2  - write data                (master -> slave)
//            writeEnable1/2- write strobes             (master -> slave)
//            ready         - array valid, writes taken (slave  -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] readAdr1;
  logic [ADDR_WIDTH-1:0] readAdr2;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic [ADDR_WIDTH-1:0] writeAdr1;
  logic [ADDR_WIDTH-1:0] writeAdr2;
  logic [DATA_WIDTH-1:0] writeData1;
  logic [DATA_WIDTH-1:0] writeData2;
  logic                  writeEnable1;
  logic                  writeEnable2;
  logic                  ready;

  modport master (
    output readAdr1, readAdr2,
    output writeAdr1, writeAdr2, writeData1, writeData2,
    output writeEnable1, writeEnable2,
    input  readData1, readData2, ready
  );

  modport slave (
    input  readAdr1, readAdr2,
    input  writeAdr1, writeAdr2, writeData1, writeData2,
    input  writeEnable1, writeEnable2,
    output readData1, readData2, ready
  );

endinterface : register_file_mp_if
`default_nettype wire

// File: rtl/register_file_mp_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_clear_seq
// Purpose  : Post-reset clear sequencer. Walks clearIdx 0..DEPTH-1, asking
//            the array to zero one entry per edge, then raises ready.
// Ports    : clk    - clock, rising edge
//            reset  - asynchronous active-high reset
//            clrWe  - 1 while the array entry at clrAdr must be zeroed
//            clrAdr - entry being cleared this cycle
//            ready  - registered; 1 once the array is valid
// Revision : 1.0 - initial release
// ============================================================================
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH     = c_DEFAULT_ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  clrWe,
  output logic [ADDR_WIDTH-1:0] clrAdr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = '1;

  rf_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_clearIdx;
  logic                  r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clearIdx <= '0;
      if (CLEAR_ON_RESET != 0) begin
        r_state <= RF_CLEAR;
        r_ready <= 1'b0;
      end else begin
        r_state <= RF_RUN;
        r_ready <= 1'b1;
      end
    end else begin
      case (r_state)
        RF_CLEAR: begin
          // The last entry is cleared on this edge; the index parks at the
          // top rather than wrapping back to 0.
          if (r_clearIdx == c_LAST_IDX) begin
            r_state <= RF_RUN;
            r_ready <= 1'b1;
          end else begin
            r_clearIdx <= r_clearIdx + 1'b1;
          end
        end
        RF_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state    <= RF_CLEAR;
          r_clearIdx <= '0;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign clrWe  = (r_state == RF_CLEAR);
  assign clrAdr = r_clearIdx;
  assign ready  = r_ready;

endmodule : regfile_clear_seq
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Purpose  : Parametrised 2-write / 2-read register file with optional
//            hardwired zero entry and a post-reset clear sequence.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous active-high reset
//            rf    - register_file_mp_if.slave (read/write ports, ready)
// Params   : DATA_WIDTH, ADDR_WIDTH (DEPTH = 2**ADDR_WIDTH), ZERO_REG,
//            CLEAR_ON_RESET
// Macro    : REGFILE_BYPASS_EN - forward same-cycle write data to reads
// Revision : 1.0 - initial release
// ============================================================================
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = c_DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset,
  register_file_mp_if.slave  rf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_clrWe;
  logic [ADDR_WIDTH-1:0] w_clrAdr;
  logic                  w_ready;
  logic                  w_we1;
  logic                  w_we2;

  regfile_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk    (clk),
    .reset  (reset),
    .clrWe  (w_clrWe),
    .clrAdr (w_clrAdr),
    .ready  (w_ready)
  );

  // Writes are only honoured once the array is valid; entry 0 is read-only
  // when it is the hardwired zero register.
  assign w_we1 = rf.writeEnable1 && w_ready &&
                 !((ZERO_REG != 0) && (rf.writeAdr1 == '0));
  assign w_we2 = rf.writeEnable2 && w_ready &&
                 !((ZERO_REG != 0) && (rf.writeAdr2 == '0));

  // No reset on the storage: contents are defined by the clear sequence.
  // Port 2 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (w_clrWe) begin
      r_mem[w_clrAdr] <= '0;
    end else begin
      if (w_we1) r_mem[rf.writeAdr1] <= rf.writeData1;
      if (w_we2) r_mem[rf.writeAdr2] <= rf.writeData2;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] ra);
    logic [DATA_WIDTH-1:0] v;
    v = r_mem[ra];
`ifdef REGFILE_BYPASS_EN
    // Port 2 checked last so it has priority when both ports hit.
    if (rf.writeEnable1 && (rf.writeAdr1 == ra)) v = rf.writeData1;
    if (rf.writeEnable2 && (rf.writeAdr2 == ra)) v = rf.writeData2;
`endif
    if (!w_ready || ((ZERO_REG != 0) && (ra == '0))) v = '0;
    return v;
  endfunction

  assign rf.readData1 = f_read(rf.readAdr1);
  assign rf.readData2 = f_read(rf.readAdr2);
  assign rf.ready     = w_ready;

endmodule : register_file_mp
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_mp
// Purpose  : Randomised self-checking bench for register_file_mp. Two DUTs:
//            u0 default (64x64, no zero reg) and u1 (16x16, ZERO_REG=1),
//            both driven from the same stimulus, each checked against an
//            array model of the register file behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

  logic clk;
  logic reset;

  register_file_mp_if #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) rf0 ();
  register_file_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) rf1 ();

  register_file_mp #(
    .DATA_WIDTH(64), .ADDR_WIDTH(6), .ZERO_REG(0), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk   (clk),
    .reset (reset),
    .rf    (rf0)
  );

  register_file_mp #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1), .CLEAR_ON_RESET(1)
  ) u1 (
    .clk   (clk),
    .reset (reset),
    .rf    (rf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-unit storage and count of reset-free edges.
  logic [63:0] m_mem [2][64];
  int          m_cnt [2];

  // Current stimulus (shared by both units; truncated for u1).
  logic        t_we1, t_we2;
  logic [5:0]  t_wa1, t_wa2;
  logic [63:0] t_wd1, t_wd2;

  function automatic int depth_of(input int u);
    return (u == 0) ? 64 : 16;
  endfunction

  function automatic logic [63:0] mask_of(input int u);
    return (u == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
  endfunction

  function automatic logic [5:0] adr_of(input int u, input logic [5:0] a);
    return (u == 0) ? a : {2'b00, a[3:0]};
  endfunction

  function automatic logic [63:0] exp_rd(input int u, input logic [5:0] ra);
    logic [5:0]  a;
    logic [63:0] v;
    a = adr_of(u, ra);
    if (m_cnt[u] < depth_of(u)) return 64'd0;
    v = m_mem[u][a];
`ifdef REGFILE_BYPASS_EN
    if (t_we1 && adr_of(u, t_wa1) == a) v = t_wd1 & mask_of(u);
    if (t_we2 && adr_of(u, t_wa2) == a) v = t_wd2 & mask_of(u);
`endif
    if (u == 1 && a == 6'd0) v = 64'd0;
    return v;
  endfunction

  function automatic logic [63:0] exp_rdy(input int u);
    return (m_cnt[u] >= depth_of(u)) ? 64'd1 : 64'd0;
  endfunction

  // Called at each rising edge with the inputs that were applied.
  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        m_cnt[u] = 0;
      end else if (m_cnt[u] >= depth_of(u)) begin
        if (t_we1 && !(u == 1 && adr_of(u, t_wa1) == 6'd0))
          m_mem[u][adr_of(u, t_wa1)] = t_wd1 & mask_of(u);
        if (t_we2 && !(u == 1 && adr_of(u, t_wa2) == 6'd0))
          m_mem[u][adr_of(u, t_wa2)] = t_wd2 & mask_of(u);
      end else begin
        m_cnt[u]++;
        if (m_cnt[u] == depth_of(u))
          for (int a = 0; a < 64; a++) m_mem[u][a] = 64'd0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, check at the falling edge, advance the
  // model at the rising edge. Entered and left at posedge+1.
  task automatic drive_cycle(input logic [5:0] ra1, input logic [5:0] ra2,
                             input logic we1, input logic [5:0] wa1, input logic [63:0] wd1,
                             input logic we2, input logic [5:0] wa2, input logic [63:0] wd2);
    t_we1 = we1; t_wa1 = wa1; t_wd1 = wd1;
    t_we2 = we2; t_wa2 = wa2; t_wd2 = wd2;
    rf0.readAdr1 = ra1;        rf0.readAdr2 = ra2;
    rf0.writeEnable1 = we1;    rf0.writeAdr1 = wa1;        rf0.writeData1 = wd1;
    rf0.writeEnable2 = we2;    rf0.writeAdr2 = wa2;        rf0.writeData2 = wd2;
    rf1.readAdr1 = ra1[3:0];   rf1.readAdr2 = ra2[3:0];
    rf1.writeEnable1 = we1;    rf1.writeAdr1 = wa1[3:0];   rf1.writeData1 = wd1[15:0];
    rf1.writeEnable2 = we2;    rf1.writeAdr2 = wa2[3:0];   rf1.writeData2 = wd2[15:0];
    @(negedge clk);
    check("u0_ready", 64'(rf0.ready), exp_rdy(0));
    check("u0_rd1",   rf0.readData1,  exp_rd(0, ra1));
    check("u0_rd2",   rf0.readData2,  exp_rd(0, ra2));
    check("u1_ready", 64'(rf1.ready), exp_rdy(1));
    check("u1_rd1",   64'(rf1.readData1), exp_rd(1, ra1));
    check("u1_rd2",   64'(rf1.readData2), exp_rd(1, ra2));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_read(input logic [5:0] ra1, input logic [5:0] ra2);
    drive_cycle(ra1, ra2, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
  endtask

  task automatic rand_cycle(input int span);
    drive_cycle(6'($urandom_range(0, span)), 6'($urandom_range(0, span)),
                1'($urandom), 6'($urandom_range(0, span)), {$urandom, $urandom},
                1'($urandom), 6'($urandom_range(0, span)), {$urandom, $urandom});
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) idle_read(6'(i), 6'(i + 32));
  endtask

  initial begin
    reset = 1'b1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    t_we1 = 1'b0; t_we2 = 1'b0;
    t_wa1 = '0;   t_wa2 = '0;
    t_wd1 = '0;   t_wd2 = '0;
    rf0.readAdr1 = '0; rf0.readAdr2 = '0; rf0.writeEnable1 = 1'b0; rf0.writeEnable2 = 1'b0;
    rf0.writeAdr1 = '0; rf0.writeAdr2 = '0; rf0.writeData1 = '0; rf0.writeData2 = '0;
    rf1.readAdr1 = '0; rf1.readAdr2 = '0; rf1.writeEnable1 = 1'b0; rf1.writeEnable2 = 1'b0;
    rf1.writeAdr1 = '0; rf1.writeAdr2 = '0; rf1.writeData1 = '0; rf1.writeData2 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", 64'(rf0.ready), 64'd0);
    check("rst_ready1", 64'(rf1.ready), 64'd0);
    reset = 1'b0;

    // Clear phase: writes to the top entry must be dropped while not ready.
    for (int i = 0; i < 64; i++)
      drive_cycle(6'($urandom_range(0, 63)), 6'd63,
                  1'b1, 6'd63, 64'h7, 1'b1, 6'd63, 64'h7);
    check("clr_done", 64'(rf0.ready), 64'd1);
    read_all();

    // Single write to 5, then a both-port collision on 9.
    drive_cycle(6'd5, 6'd5, 1'b1, 6'd5, 64'hAA, 1'b0, 6'd0, 64'd0);
    drive_cycle(6'd5, 6'd9, 1'b1, 6'd9, 64'h11, 1'b1, 6'd9, 64'h22);
    idle_read(6'd9, 6'd5);
    #3;
    check("collide9", rf0.readData1, 64'h22);
    check("wr5",      rf0.readData2, 64'hAA);
    #(-3 + 3);

    // Zero register on u1: both ports write FF to address 0.
    drive_cycle(6'd0, 6'd16, 1'b1, 6'd0, 64'hFF, 1'b1, 6'd0, 64'hFF);
    idle_read(6'd0, 6'd16);

    for (int i = 0; i < 150; i++) rand_cycle(7);
    for (int i = 0; i < 150; i++) rand_cycle(63);

    // Asynchronous reset from RUN with a populated array.
    #2 reset = 1'b1;
    #1;
    check("async_rdy0", 64'(rf0.ready), 64'd0);
    check("async_rdy1", 64'(rf1.ready), 64'd0);
    check("async_rd0",  rf0.readData1,  64'd0);
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    @(posedge clk);
    model_edge();
    #1 reset = 1'b0;

    for (int i = 0; i < 64; i++) rand_cycle(63);
    read_all();
    for (int i = 0; i < 40; i++) rand_cycle(15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_register_file_mp
`default_nettype wire
